histogram_sram_denetleyici: RTL

Sequencer and owner of the dual-port histogram SRAM (`sram_histogram`, port 0 write-only, port 1 read-only, active-low chip selects, 1-cycle read latency). Per frame it clears all 256 bins, grants the SRAM to the histogram builder while pixels stream, drains the builder's read-modify-write pipeline, then scans the bins to emit a running CDF stream and `cdf_min` for the equalization stage. It sits between the histogram builder and the SRAM macro, replacing direct builder-to-SRAM wiring.

---
 rtl/histogram_sram_denetleyici.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/histogram_sram_denetleyici.sv
// Histogram SRAM sequencer: clear, builder grant, RMW drain, CDF scan.
// Optional HIST_CDF_MIN_EN keeps the cdf_min_o latch; otherwise cdf_min_o is 0.
module histogram_sram_denetleyici #(
    parameter int ADR_BIT       = 8,
    parameter int VERI_BIT      = 17,
    parameter int BOSALT_CEVRIM = 2
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic                kare_basla_i,
    input  logic                kare_bitti_i,
    input  logic                hb_wr_i,
    input  logic [ADR_BIT-1:0]  hb_waddr_i,
    input  logic [VERI_BIT-1:0] hb_wdata_i,
    input  logic                hb_rd_i,
    input  logic [ADR_BIT-1:0]  hb_raddr_i,
    output logic [VERI_BIT-1:0] hb_rdata_o,
    output logic                hb_izin_o,
    output logic                sram_csb0_o,
    output logic [ADR_BIT-1:0]  sram_addr0_o,
    output logic [VERI_BIT-1:0] sram_din0_o,
    output logic                sram_csb1_o,
    output logic [ADR_BIT-1:0]  sram_addr1_o,
    input  logic [VERI_BIT-1:0] sram_dout1_i,
    output logic                cdf_gecerli_o,
    output logic [ADR_BIT-1:0]  cdf_adres_o,
    output logic [VERI_BIT-1:0] cdf_o,
    output logic [VERI_BIT-1:0] cdf_min_o,
    output logic                tarama_bitti_o,
    output logic                mesgul_o,
    output logic                hata_o
);
    localparam logic [2:0] BOSTA   = 3'd0;
    localparam logic [2:0] TEMIZLE = 3'd1;
    localparam logic [2:0] TOPLA   = 3'd2;
    localparam logic [2:0] BOSALT  = 3'd3;
    localparam logic [2:0] TARAMA  = 3'd4;

    localparam int SW = ADR_BIT + 1;
    localparam logic [SW-1:0] SON_ADR    = SW'((1 << ADR_BIT) - 1);
    localparam logic [SW-1:0] TARAMA_SON = SW'(1 << ADR_BIT);
    localparam logic [SW-1:0] BOSALT_SON = SW'(BOSALT_CEVRIM - 1);
    localparam logic [VERI_BIT-1:0] DOYMA = '1;

    logic [2:0]          durum_q, durum_d;
    logic [SW-1:0]       sayac_q, sayac_d;
    logic                hb_izin_q, hata_q, gecerli_q, bitti_q;
    logic [ADR_BIT-1:0]  adres_q;
    logic [VERI_BIT-1:0] toplam_q, cdf_simdi;
    logic [VERI_BIT:0]   toplam_genis;
    logic                sahip, istek, hata_kur, hata_sil, tarama_giris;

    assign sahip = (durum_q == TOPLA) || (durum_q == BOSALT);
    assign istek = hb_wr_i | hb_rd_i;

    always_comb begin
        durum_d = durum_q;
        sayac_d = sayac_q + SW'(1);
        unique case (durum_q)
            BOSTA: begin
                sayac_d = '0;
                if (kare_basla_i) durum_d = TEMIZLE;
            end
            TEMIZLE: begin
                if (sayac_q == SON_ADR) begin
                    durum_d = TOPLA;
                    sayac_d = '0;
                end
            end
            TOPLA: begin
                sayac_d = '0;
                if (kare_basla_i) durum_d = TEMIZLE;
                else if (kare_bitti_i) durum_d = BOSALT;
            end
            BOSALT: begin
                if (kare_basla_i) begin
                    durum_d = TEMIZLE;
                    sayac_d = '0;
                end else if (sayac_q == BOSALT_SON) begin
                    durum_d = TARAMA;
                    sayac_d = '0;
                end
            end
            TARAMA: begin
                if (sayac_q == TARAMA_SON) begin
                    durum_d = BOSTA;
                    sayac_d = '0;
                end
            end
            default: begin
                durum_d = BOSTA;
                sayac_d = '0;
            end
        endcase
    end

    // Set beats clear so an error in the start cycle is not lost.
    assign hata_kur = (istek && !sahip)
                   || (kare_basla_i && durum_q != BOSTA)
                   || (kare_bitti_i && durum_q != TOPLA);
    assign hata_sil = kare_basla_i && (durum_q == BOSTA);
    assign tarama_giris = (durum_d == TARAMA) && (durum_q != TARAMA);

    always_comb begin
        sram_csb0_o  = 1'b1;
        sram_addr0_o = '0;
        sram_din0_o  = '0;
        sram_csb1_o  = 1'b1;
        sram_addr1_o = '0;
        unique case (durum_q)
            TEMIZLE: begin
                sram_csb0_o  = 1'b0;
                sram_addr0_o = sayac_q[ADR_BIT-1:0];
            end
            TOPLA, BOSALT: begin
                sram_csb0_o  = ~hb_wr_i;
                sram_addr0_o = hb_waddr_i;
                sram_din0_o  = hb_wdata_i;
                sram_csb1_o  = ~hb_rd_i;
                sram_addr1_o = hb_raddr_i;
            end
            TARAMA: begin
                sram_csb1_o  = sayac_q[ADR_BIT];
                sram_addr1_o = sayac_q[ADR_BIT-1:0];
            end
            default: ;
        endcase
    end

    // Read data arrives one cycle after the address, so the sample is
    // the registered running sum plus the live SRAM word.
    assign toplam_genis = {1'b0, toplam_q} + {1'b0, sram_dout1_i};
    assign cdf_simdi = toplam_genis[VERI_BIT] ? DOYMA
                                              : toplam_genis[VERI_BIT-1:0];

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            durum_q   <= BOSTA;
            sayac_q   <= '0;
            hb_izin_q <= 1'b0;
            hata_q    <= 1'b0;
            gecerli_q <= 1'b0;
            adres_q   <= '0;
            toplam_q  <= '0;
            bitti_q   <= 1'b0;
        end else begin
            durum_q   <= durum_d;
            sayac_q   <= sayac_d;
            hb_izin_q <= (durum_d == TOPLA) || (durum_d == BOSALT);
            hata_q    <= (hata_q & ~hata_sil) | hata_kur;
            gecerli_q <= (durum_q == TARAMA) && !sayac_q[ADR_BIT];
            if ((durum_q == TARAMA) && !sayac_q[ADR_BIT])
                adres_q <= sayac_q[ADR_BIT-1:0];
            if (tarama_giris)
                toplam_q <= '0;
            else if (gecerli_q)
                toplam_q <= cdf_simdi;
            bitti_q   <= (durum_q == TARAMA) && (durum_d == BOSTA);
        end
    end

`ifdef HIST_CDF_MIN_EN
    logic [VERI_BIT-1:0] cdf_min_q;
    logic                bulundu_q;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            cdf_min_q <= '0;
            bulundu_q <= 1'b0;
        end else if (tarama_giris) begin
            cdf_min_q <= '0;
            bulundu_q <= 1'b0;
        end else if (gecerli_q && !bulundu_q && (sram_dout1_i != '0)) begin
            cdf_min_q <= cdf_simdi;
            bulundu_q <= 1'b1;
        end
    end

    assign cdf_min_o = cdf_min_q;
`else
    assign cdf_min_o = '0;
`endif

    assign hb_rdata_o     = sram_dout1_i;
    assign hb_izin_o      = hb_izin_q;
    assign cdf_gecerli_o  = gecerli_q;
    assign cdf_adres_o    = adres_q;
    assign cdf_o          = gecerli_q ? cdf_simdi : '0;
    assign tarama_bitti_o = bitti_q;
    assign mesgul_o       = (durum_q != BOSTA);
    assign hata_o         = hata_q;
endmodule
